alu_issue_stage: RTL and testbench

- Upstream command front-end for the 16-bit combinational ALU.
- Accepts operation commands over a valid/ready handshake and buffers them in a DEPTH-entry FIFO.
- Issues one command at a time on registered ALU operand/select lines, then waits SETTLE cycles for the combinational result to settle.
- Captures the masked result into an output register presented over a second valid/ready handshake.

---
 rtl/alu_issue_stage.sv | 150 +++++++++++++++
 tb/tb_alu_issue_stage.sv | 429 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_stage.sv
// Command front-end for the 16-bit combinational ALU: buffers commands in a FIFO,
// drives registered operands for SETTLE cycles, then captures a masked result.
module alu_issue_stage #(
  parameter int DEPTH  = 4,
  parameter int SETTLE = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [1:0]                in_op,
  input  logic                      in_sub,
  input  logic                      in_cin,
  input  logic [15:0]               in_opa,
  input  logic [15:0]               in_opb,
  output logic [1:0]                alu_sel,
  output logic [15:0]               alu_opa,
  output logic [15:0]               alu_opb,
  output logic                      alu_cin,
  output logic                      alu_sub,
  input  logic [15:0]               alu_lo,
  input  logic [15:0]               alu_hi,
  input  logic                      alu_cout,
  input  logic                      alu_ovf,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [1:0]                out_op,
  output logic [15:0]               out_lo,
  output logic [15:0]               out_hi,
  output logic                      out_cout,
  output logic                      out_ovf,
  output logic [$clog2(DEPTH):0]    fifo_count,
  output logic                      busy
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [PTR_W:0]   FULL_COUNT = (PTR_W + 1)'(DEPTH);
  localparam logic [CNT_W-1:0] LAST_CNT   = CNT_W'(SETTLE - 1);

  typedef struct packed {
    logic [1:0]  op;
    logic        sub;
    logic        cin;
    logic [15:0] opa;
    logic [15:0] opb;
  } cmd_t;

  typedef enum logic [1:0] {IDLE, DRIVE, WAIT_OUT} state_t;

  cmd_t             mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  state_t           state;
  logic [CNT_W-1:0] cnt;

  logic push;
  logic pop;
  logic fifo_empty;
  logic out_free;
  logic settle_done;
  logic capture;
  cmd_t head;

  // A full FIFO refuses input even when it pops that edge: no pass-through path.
  assign in_ready    = fifo_count < FULL_COUNT;
  assign push        = in_valid && in_ready;
  assign fifo_empty  = (fifo_count == '0);
  assign out_free    = !out_valid || out_ready;
  assign settle_done = (cnt == LAST_CNT);
  assign capture     = ((state == DRIVE && settle_done) || state == WAIT_OUT) && out_free;
  assign pop         = !fifo_empty && (state == IDLE || capture);
  assign head        = mem[rd_ptr];
  assign busy        = (state != IDLE) || !fifo_empty || out_valid;

  // NOTE: the storage array has no reset; the count and pointers alone define
  // which entries are live, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{op: in_op, sub: in_sub, cin: in_cin, opa: in_opa, opb: in_opb};
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + (PTR_W + 1)'(1);
        2'b01:   fifo_count <= fifo_count - (PTR_W + 1)'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      alu_sel   <= '0;
      alu_opa   <= '0;
      alu_opb   <= '0;
      alu_cin   <= 1'b0;
      alu_sub   <= 1'b0;
      out_valid <= 1'b0;
      out_op    <= '0;
      out_lo    <= '0;
      out_hi    <= '0;
      out_cout  <= 1'b0;
      out_ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE:     if (pop) state <= DRIVE;
        DRIVE: begin
          if (!settle_done)  cnt   <= cnt + CNT_W'(1);
          else if (capture)  state <= pop ? DRIVE : IDLE;
          else               state <= WAIT_OUT;
        end
        WAIT_OUT: if (capture) state <= pop ? DRIVE : IDLE;
        default:  state <= IDLE;
      endcase

      // Loading the issue register restarts the settle window.
      if (pop) begin
        alu_sel <= head.op;
        alu_opa <= head.opa;
        alu_opb <= head.opb;
        alu_cin <= head.cin;
        alu_sub <= head.sub;
        cnt     <= '0;
      end

      if (capture) begin
        out_valid <= 1'b1;
        out_op    <= alu_sel;
        out_lo    <= alu_lo;
        out_hi    <= alu_sel[1] ? alu_hi : 16'h0000;
        out_cout  <= alu_sel[1] ? 1'b0 : alu_cout;
        out_ovf   <= (alu_sel == 2'b01) ? alu_ovf : 1'b0;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: a behavioural ALU drives the result
// lines and a queue-based reference predicts every consumed result.
module tb_alu_issue_stage;

  localparam int DEPTH  = 4;
  localparam int SETTLE = 2;

  typedef struct packed {
    logic [1:0]  op;
    logic        sub;
    logic        cin;
    logic [15:0] opa;
    logic [15:0] opb;
  } cmd_t;

  typedef struct packed {
    logic [1:0]  op;
    logic [15:0] lo;
    logic [15:0] hi;
    logic        cout;
    logic        ovf;
  } res_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [1:0] in_op = '0;
  logic in_sub = 1'b0;
  logic in_cin = 1'b0;
  logic [15:0] in_opa = '0;
  logic [15:0] in_opb = '0;
  logic [1:0] alu_sel;
  logic [15:0] alu_opa, alu_opb;
  logic alu_cin, alu_sub;
  logic [15:0] alu_lo, alu_hi;
  logic alu_cout, alu_ovf;
  logic out_valid;
  logic out_ready = 1'b0;
  logic [1:0] out_op;
  logic [15:0] out_lo, out_hi;
  logic out_cout, out_ovf;
  logic [$clog2(DEPTH):0] fifo_count;
  logic busy;

  int checks = 0;
  int errors = 0;
  int n_results = 0;
  res_t exp_q[$];

  always #5 clk = ~clk;

  alu_issue_stage #(.DEPTH(DEPTH), .SETTLE(SETTLE)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_sub(in_sub),
    .in_cin(in_cin), .in_opa(in_opa), .in_opb(in_opb),
    .alu_sel(alu_sel), .alu_opa(alu_opa), .alu_opb(alu_opb), .alu_cin(alu_cin),
    .alu_sub(alu_sub), .alu_lo(alu_lo), .alu_hi(alu_hi), .alu_cout(alu_cout),
    .alu_ovf(alu_ovf), .out_valid(out_valid), .out_ready(out_ready), .out_op(out_op),
    .out_lo(out_lo), .out_hi(out_hi), .out_cout(out_cout), .out_ovf(out_ovf),
    .fifo_count(fifo_count), .busy(busy)
  );

  // Combinational ALU; fields the issue stage must mask carry deliberate junk.
  always_comb begin
    alu_lo   = '0;
    alu_hi   = 16'hA5A5 ^ alu_opa;
    alu_cout = 1'b1;
    alu_ovf  = 1'b1;
    case (alu_sel)
      2'b00: {alu_cout, alu_lo} = {1'b0, alu_opa} + {1'b0, alu_opb} + {16'h0000, alu_cin};
      2'b01: begin
        if (alu_sub) begin
          alu_lo   = alu_opa - alu_opb;
          alu_cout = alu_opa < alu_opb;
          alu_ovf  = (alu_opa[15] != alu_opb[15]) && (alu_lo[15] != alu_opa[15]);
        end else begin
          {alu_cout, alu_lo} = {1'b0, alu_opa} + {1'b0, alu_opb};
          alu_ovf = (alu_opa[15] == alu_opb[15]) && (alu_lo[15] != alu_opa[15]);
        end
      end
      2'b10: {alu_hi, alu_lo} = 32'(alu_opa) * 32'(alu_opb);
      default: begin
        alu_lo = alu_opa >> alu_opb[3:0];
        alu_hi = alu_opa << alu_opb[3:0];
      end
    endcase
  end

  // Expected captured result, from plain integer arithmetic plus masking rules.
  function automatic res_t ref_result(input cmd_t c);
    res_t r;
    int unsigned u;
    int s;
    longint unsigned p;
    r = '0;
    r.op = c.op;
    case (c.op)
      2'd0: begin
        u = int'(c.opa) + int'(c.opb) + int'(c.cin);
        r.lo = u[15:0];
        r.cout = (u > 32'hFFFF);
      end
      2'd1: begin
        if (c.sub) begin
          u = int'(c.opa) - int'(c.opb);
          s = int'($signed(c.opa)) - int'($signed(c.opb));
          r.cout = (c.opa < c.opb);
        end else begin
          u = int'(c.opa) + int'(c.opb);
          s = int'($signed(c.opa)) + int'($signed(c.opb));
          r.cout = (u > 32'hFFFF);
        end
        r.lo = u[15:0];
        r.ovf = (s > 32767) || (s < -32768);
      end
      2'd2: begin
        p = longint'(c.opa) * longint'(c.opb);
        r.lo = p[15:0];
        r.hi = p[31:16];
      end
      default: begin
        r.lo = c.opa >> (c.opb % 16);
        r.hi = c.opa << (c.opb % 16);
      end
    endcase
    return r;
  endfunction

  function automatic cmd_t mk(input logic [1:0] op, input logic sub, input logic cin,
                              input logic [15:0] a, input logic [15:0] b);
    cmd_t c;
    c.op = op; c.sub = sub; c.cin = cin; c.opa = a; c.opb = b;
    return c;
  endfunction

  function automatic cmd_t rand_cmd();
    return mk(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              16'($urandom), 16'($urandom));
  endfunction

  task automatic drive_cmd(input cmd_t c);
    in_op = c.op; in_sub = c.sub; in_cin = c.cin; in_opa = c.opa; in_opb = c.opb;
  endtask

  // Scoreboard: predicts on acceptance, compares on consumption, and checks
  // that a held result stays put while backpressured.
  logic hold_prev = 1'b0;
  res_t held_prev;
  always @(negedge clk) begin
    res_t e;
    res_t act;
    if (!rst_n) begin
      hold_prev = 1'b0;
    end else begin
      act = '{op: out_op, lo: out_lo, hi: out_hi, cout: out_cout, ovf: out_ovf};
      if (hold_prev) begin
        checks++;
        if (out_valid !== 1'b1 || act !== held_prev) begin
          errors++;
          $display("FAIL hold_stable: got valid=%b %h, required valid=1 %h", out_valid, act, held_prev);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        n_results++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL result_order: got unexpected result %h, required none", act);
        end else begin
          e = exp_q.pop_front();
          if (act !== e) begin
            errors++;
            $display("FAIL result_data: got op=%0d lo=%h hi=%h c=%b v=%b, required op=%0d lo=%h hi=%h c=%b v=%b",
                     act.op, act.lo, act.hi, act.cout, act.ovf, e.op, e.lo, e.hi, e.cout, e.ovf);
          end
        end
      end
      checks++;
      if (in_ready !== (int'(fifo_count) < DEPTH)) begin
        errors++;
        $display("FAIL in_ready_rule: got %b with fifo_count=%0d", in_ready, fifo_count);
      end
      if (in_valid && in_ready) exp_q.push_back(ref_result(mk(in_op, in_sub, in_cin, in_opa, in_opb)));
      hold_prev = out_valid && !out_ready;
      held_prev = act;
    end
  end

  // Present one command and hold it until accepted; returns 1ns after the accepting edge.
  task automatic send(input cmd_t c);
    int n = 0;
    drive_cmd(c);
    in_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 50) begin
        checks++; errors++;
        $display("FAIL send_timeout: in_ready stuck at 0, required 1");
        break;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (out_valid) begin lat = k; break; end
    end
  endtask

  task automatic drain(input string tag);
    int n = 0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    while ((exp_q.size() != 0 || busy) && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (exp_q.size() != 0 || busy) begin
      errors++;
      $display("FAIL %s_drain: got pending=%0d busy=%b, required 0 and 0", tag, exp_q.size(), busy);
    end
  endtask

  task automatic test_reset();
    checks++;
    if ({in_ready, out_valid, busy, fifo_count} !== {1'b1, 1'b0, 1'b0, 3'd0} ||
        {alu_sel, alu_opa, alu_opb, alu_cin, alu_sub} !== '0 ||
        {out_op, out_lo, out_hi, out_cout, out_ovf} !== '0) begin
      errors++;
      $display("FAIL reset_state: got ready=%b valid=%b busy=%b count=%0d alu_opa=%h out_lo=%h, required 1 0 0 0 0000 0000",
               in_ready, out_valid, busy, fifo_count, alu_opa, out_lo);
    end
  endtask

  task automatic test_add_latency(input string tag);
    int lat;
    out_ready = 1'b1;
    send(mk(2'b00, 1'b0, 1'b1, 16'h1234, 16'h0FFF));
    wait_valid(lat);
    checks++;
    if (lat !== 3) begin
      errors++;
      $display("FAIL %s_latency: got %0d cycles, required 3", tag, lat);
    end
    checks++;
    if ({out_lo, out_hi, out_cout, out_ovf} !== {16'h2234, 16'h0000, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL %s_data: got lo=%h hi=%h c=%b v=%b, required 2234 0000 0 0", tag, out_lo, out_hi, out_cout, out_ovf);
    end
    drain(tag);
  endtask

  task automatic test_sub();
    int lat;
    out_ready = 1'b1;
    send(mk(2'b01, 1'b1, 1'b0, 16'h8000, 16'h0001));
    wait_valid(lat);
    checks++;
    if ({out_op, out_lo, out_hi, out_cout, out_ovf} !== {2'b01, 16'h7FFF, 16'h0000, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL sub_data: got op=%0d lo=%h hi=%h c=%b v=%b, required 1 7fff 0000 0 1",
               out_op, out_lo, out_hi, out_cout, out_ovf);
    end
    drain("sub");
  endtask

  task automatic test_back_to_back();
    int seen = 0;
    int when[2];
    res_t got[2];
    out_ready = 1'b1;
    send(mk(2'b10, 1'b0, 1'b0, 16'h1234, 16'h0100));
    send(mk(2'b11, 1'b0, 1'b0, 16'h00F0, 16'h0004));
    for (int k = 1; k <= 20 && seen < 2; k++) begin
      @(posedge clk); #1;
      if (out_valid) begin
        when[seen] = k;
        got[seen] = '{op: out_op, lo: out_lo, hi: out_hi, cout: out_cout, ovf: out_ovf};
        seen++;
      end
    end
    checks++;
    if (seen != 2) begin
      errors++;
      $display("FAIL b2b_count: got %0d results, required 2", seen);
    end else begin
      checks++;
      if (got[0] !== '{op: 2'b10, lo: 16'h3400, hi: 16'h0012, cout: 1'b0, ovf: 1'b0}) begin
        errors++;
        $display("FAIL b2b_mul: got %h, required op=2 lo=3400 hi=0012", got[0]);
      end
      checks++;
      if (got[1] !== '{op: 2'b11, lo: 16'h000F, hi: 16'h0F00, cout: 1'b0, ovf: 1'b0}) begin
        errors++;
        $display("FAIL b2b_shift: got %h, required op=3 lo=000f hi=0f00", got[1]);
      end
      checks++;
      if (when[1] - when[0] != SETTLE) begin
        errors++;
        $display("FAIL b2b_spacing: got %0d cycles, required %0d", when[1] - when[0], SETTLE);
      end
    end
    drain("b2b");
  endtask

  task automatic test_backpressure();
    cmd_t cmds[8];
    int idx = 0;
    int base;
    logic taken;
    foreach (cmds[i]) cmds[i] = rand_cmd();
    out_ready = 1'b0;
    for (int k = 0; k < 30 && idx < 8; k++) begin
      drive_cmd(cmds[idx]);
      in_valid = 1'b1;
      @(negedge clk); taken = in_ready;
      @(posedge clk); #1;
      if (taken) idx++;
    end
    checks++;
    if (idx !== DEPTH + 2 || in_ready !== 1'b0 || int'(fifo_count) !== DEPTH) begin
      errors++;
      $display("FAIL bp_capacity: got accepted=%0d ready=%b count=%0d, required %0d 0 %0d",
               idx, in_ready, fifo_count, DEPTH + 2, DEPTH);
    end
    in_valid = 1'b0;
    base = n_results;
    drain("bp");
    checks++;
    if (n_results - base !== DEPTH + 2 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release: got results=%0d ready=%b, required %0d 1", n_results - base, in_ready, DEPTH + 2);
    end
  endtask

  task automatic test_simul_push_pop();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(rand_cmd());
    repeat (6) begin @(posedge clk); #1; end
    checks++;
    if (fifo_count !== 3'd2 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL pp_setup: got count=%0d valid=%b, required 2 1", fifo_count, out_valid);
    end
    out_ready = 1'b1;
    drive_cmd(rand_cmd());
    in_valid = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++;
    if (fifo_count !== 3'd2 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL pp_count: got count=%0d valid=%b, required 2 1", fifo_count, out_valid);
    end
    drain("pp");
  endtask

  task automatic test_reset_mid_op();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) send(rand_cmd());
    repeat (6) begin @(posedge clk); #1; end
    checks++;
    if (fifo_count !== 3'd3 || out_valid !== 1'b1 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_setup: got count=%0d valid=%b, required 3 1", fifo_count, out_valid);
    end
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    checks++;
    if (out_valid !== 1'b0 || fifo_count !== 3'd0 || busy !== 1'b0 ||
        {alu_sel, alu_opa, alu_opb, alu_cin, alu_sub} !== '0) begin
      errors++;
      $display("FAIL rst_midop: got valid=%b count=%0d busy=%b alu_opa=%h alu_opb=%h, required 0 0 0 0000 0000",
               out_valid, fifo_count, busy, alu_opa, alu_opb);
    end
    @(posedge clk); #3;
    rst_n = 1'b1;
    test_add_latency("post_rst");
  endtask

  task automatic test_random();
    logic taken = 1'b0;
    for (int k = 0; k < 400; k++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      if (!in_valid || taken) begin
        drive_cmd(rand_cmd());
        in_valid = 1'($urandom_range(0, 1));
      end
      @(negedge clk); taken = in_valid && in_ready;
      @(posedge clk); #1;
    end
    drain("random");
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    @(posedge clk); #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    test_add_latency("add");
    test_sub();
    test_back_to_back();
    test_backpressure();
    test_simul_push_pop();
    test_reset_mid_op();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
